// File: rtl/time_set_if.sv
// Button inputs and edit-register outputs of the time/alarm setting controller.
interface time_set_if;
    logic       btn_mode;
    logic       btn_alm;
    logic       btn_inc;
    logic [5:0] sec;
    logic [5:0] min;
    logic [5:0] hour;
    logic       time_c;
    logic       alm_c;
    logic       editing;
    logic [1:0] field;

    modport master (
        output btn_mode, btn_alm, btn_inc,
        input  sec, min, hour, time_c, alm_c, editing, field
    );

    modport slave (
        input  btn_mode, btn_alm, btn_inc,
        output sec, min, hour, time_c, alm_c, editing, field
    );
endinterface

// File: rtl/time_set_ctrl.sv
// Time/alarm setting controller: debounced buttons drive a HOUR/MIN/SEC edit FSM
// with one-cycle load strobes. Optional auto-repeat on btn_inc: TIME_SET_AUTOREPEAT_EN.

module time_set_btn #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);
    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

    logic          s1, s2;
    logic          lvl, lvl_q;
    logic          arm;
    logic [1:0]    vld_pipe;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            lvl      <= 1'b0;
            lvl_q    <= 1'b0;
            arm      <= 1'b0;
            vld_pipe <= '0;
            cnt      <= '0;
        end else begin
            s1       <= raw;
            s2       <= s1;
            lvl_q    <= lvl;
            vld_pipe <= {vld_pipe[0], 1'b1};
            // Arm only once the real button has been seen released, so a button
            // held through reset cannot fire a press when it debounces high.
            if (vld_pipe[1] && !s2 && !lvl)
                arm <= 1'b1;
            if (s2 != lvl) begin
                if (cnt == DEB_LAST) begin
                    lvl <= s2;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign level = lvl & arm;
    assign press = lvl & ~lvl_q & arm;
endmodule

module time_set_ctrl #(
    parameter int DEB_CYCLES = 500000,
    parameter int REP_DELAY  = 25000000,
    parameter int REP_PERIOD = 10000000
) (
    input  logic        clk,
    input  logic        rst,
    time_set_if.slave   ts
);
    localparam int NUM_BTN  = 3;
    localparam int BTN_MODE = 0;
    localparam int BTN_ALM  = 1;
    localparam int BTN_INC  = 2;

    typedef enum logic [2:0] {IDLE, HOUR, MIN, SEC, COMMIT} state_t;

    logic [NUM_BTN-1:0] btn_raw, btn_lvl, btn_press;
    logic               p_mode, p_alm, p_inc, inc_ev, rep_tick, in_edit;
    logic               unused_lvl;

    state_t     state, state_nxt;
    logic       target, target_nxt;   // 0 = current time, 1 = alarm
    logic [5:0] sec_q, min_q, hour_q;
    logic [5:0] sec_nxt, min_nxt, hour_nxt;

    assign btn_raw = {ts.btn_inc, ts.btn_alm, ts.btn_mode};

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        time_set_btn #(.DEB_CYCLES(DEB_CYCLES)) u_btn (
            .clk   (clk),
            .rst   (rst),
            .raw   (btn_raw[g]),
            .level (btn_lvl[g]),
            .press (btn_press[g])
        );
    end

    assign p_mode     = btn_press[BTN_MODE];
    assign p_alm      = btn_press[BTN_ALM];
    assign p_inc      = btn_press[BTN_INC];
    assign unused_lvl = ^btn_lvl;
    assign in_edit    = (state == HOUR) || (state == MIN) || (state == SEC);
    assign inc_ev     = p_inc | rep_tick;

`ifdef TIME_SET_AUTOREPEAT_EN
    localparam int REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
    localparam int RW      = $clog2(REP_MAX + 1);
    localparam logic [RW-1:0] DLY_LAST = RW'(REP_DELAY - 1);
    localparam logic [RW-1:0] PER_LAST = RW'(REP_PERIOD - 1);

    logic [RW-1:0] rep_cnt;
    logic          rep_first;

    assign rep_tick = in_edit && btn_lvl[BTN_INC] && !p_inc &&
                      (rep_cnt == (rep_first ? DLY_LAST : PER_LAST));

    // Counter restarts on every fresh press, field change, release or exit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rep_cnt   <= '0;
            rep_first <= 1'b1;
        end else if (!in_edit || !btn_lvl[BTN_INC] || p_inc || p_mode) begin
            rep_cnt   <= '0;
            rep_first <= 1'b1;
        end else if (rep_tick) begin
            rep_cnt   <= '0;
            rep_first <= 1'b0;
        end else begin
            rep_cnt   <= rep_cnt + 1'b1;
        end
    end
`else
    // Constant zero; repeat timing parameters are inert in this build.
    assign rep_tick = (REP_DELAY < 0) && (REP_PERIOD < 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            target <= 1'b0;
            sec_q  <= '0;
            min_q  <= '0;
            hour_q <= '0;
        end else begin
            state  <= state_nxt;
            target <= target_nxt;
            sec_q  <= sec_nxt;
            min_q  <= min_nxt;
            hour_q <= hour_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        target_nxt = target;
        sec_nxt    = sec_q;
        min_nxt    = min_q;
        hour_nxt   = hour_q;
        case (state)
            IDLE: begin
                if (p_mode) begin
                    state_nxt  = HOUR;
                    target_nxt = 1'b0;
                end else if (p_alm) begin
                    state_nxt  = HOUR;
                    target_nxt = 1'b1;
                end
            end
            HOUR: begin
                if (p_alm) begin
                    state_nxt = IDLE;
                end else begin
                    if (inc_ev) hour_nxt = (hour_q >= 6'd23) ? 6'd0 : hour_q + 6'd1;
                    if (p_mode) state_nxt = MIN;
                end
            end
            MIN: begin
                if (p_alm) begin
                    state_nxt = IDLE;
                end else begin
                    if (inc_ev) min_nxt = (min_q >= 6'd59) ? 6'd0 : min_q + 6'd1;
                    if (p_mode) state_nxt = SEC;
                end
            end
            SEC: begin
                if (p_alm) begin
                    state_nxt = IDLE;
                end else begin
                    if (inc_ev) sec_nxt = (sec_q >= 6'd59) ? 6'd0 : sec_q + 6'd1;
                    if (p_mode) state_nxt = COMMIT;
                end
            end
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ts.editing = in_edit;
        ts.time_c  = (state == COMMIT) && !target;
        ts.alm_c   = (state == COMMIT) && target;
        case (state)
            HOUR:    ts.field = 2'd1;
            MIN:     ts.field = 2'd2;
            SEC:     ts.field = 2'd3;
            default: ts.field = 2'd0;
        endcase
    end

    assign ts.sec  = sec_q;
    assign ts.min  = min_q;
    assign ts.hour = hour_q;
endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl: table of button taps plus hand sequences for
// glitch rejection, latency, reset mid-edit and auto-repeat.
module tb_time_set_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   tc_cnt = 0, ac_cnt = 0;
    int   snap_h = -1, snap_m = -1, snap_s = -1;
    logic prev_tc = 1'b0, prev_ac = 1'b0;

    time_set_if bus ();

    time_set_ctrl #(.DEB_CYCLES(4), .REP_DELAY(20), .REP_PERIOD(5)) dut (
        .clk (clk),
        .rst (rst),
        .ts  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int btn;    // 0 mode, 1 alm, 2 inc
        int n;
        int hour;
        int min;
        int sec;
        int field;
        int tc;
        int ac;
        bit snap;
    } vec_t;

    vec_t vt[28];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0:       bus.btn_mode = v;
            1:       bus.btn_alm  = v;
            default: bus.btn_inc  = v;
        endcase
    endtask

    task automatic tap(input int b, input int n);
        for (int k = 0; k < n; k++) begin
            set_btn(b, 1'b1);
            repeat (10) @(negedge clk);
            set_btn(b, 1'b0);
            repeat (10) @(negedge clk);
        end
    endtask

    // Strobe monitor: counts pulses, snapshots registers, flags overlap/width.
    always @(negedge clk) begin
        if (bus.time_c && bus.alm_c) begin
            checks++; failures++;
            $display("FAIL strobe_overlap: got both high expected one");
        end
        if ((bus.time_c && prev_tc) || (bus.alm_c && prev_ac)) begin
            checks++; failures++;
            $display("FAIL strobe_width: got >1 cycle expected 1");
        end
        if (bus.time_c) tc_cnt++;
        if (bus.alm_c)  ac_cnt++;
        if (bus.time_c || bus.alm_c) begin
            snap_h = int'(bus.hour);
            snap_m = int'(bus.min);
            snap_s = int'(bus.sec);
        end
        prev_tc = bus.time_c;
        prev_ac = bus.alm_c;
    end

    initial begin
        int lat;
        int exp_rep;
        logic [5:0] h0;

        bus.btn_mode = 1'b0;
        bus.btn_alm  = 1'b0;
        bus.btn_inc  = 1'b0;

        //        btn n   hr mn sc fld tc ac snap
        vt[0]  = '{0, 1,   0, 0, 0, 1, 0, 0, 0};
        vt[1]  = '{2, 3,   3, 0, 0, 1, 0, 0, 0};
        vt[2]  = '{0, 1,   3, 0, 0, 2, 0, 0, 0};
        vt[3]  = '{2, 2,   3, 2, 0, 2, 0, 0, 0};
        vt[4]  = '{0, 1,   3, 2, 0, 3, 0, 0, 0};
        vt[5]  = '{0, 1,   3, 2, 0, 0, 1, 0, 1};
        vt[6]  = '{2, 2,   3, 2, 0, 0, 1, 0, 0};
        vt[7]  = '{1, 1,   3, 2, 0, 1, 1, 0, 0};
        vt[8]  = '{2, 3,   6, 2, 0, 1, 1, 0, 0};
        vt[9]  = '{0, 1,   6, 2, 0, 2, 1, 0, 0};
        vt[10] = '{2, 28,  6, 30, 0, 2, 1, 0, 0};
        vt[11] = '{0, 1,   6, 30, 0, 3, 1, 0, 0};
        vt[12] = '{0, 1,   6, 30, 0, 0, 1, 1, 1};
        vt[13] = '{1, 1,   6, 30, 0, 1, 1, 1, 0};
        vt[14] = '{2, 1,   7, 30, 0, 1, 1, 1, 0};
        vt[15] = '{0, 1,   7, 30, 0, 2, 1, 1, 0};
        vt[16] = '{1, 1,   7, 30, 0, 0, 1, 1, 0};
        vt[17] = '{0, 1,   7, 30, 0, 1, 1, 1, 0};
        vt[18] = '{2, 16, 23, 30, 0, 1, 1, 1, 0};
        vt[19] = '{2, 1,   0, 30, 0, 1, 1, 1, 0};
        vt[20] = '{0, 1,   0, 30, 0, 2, 1, 1, 0};
        vt[21] = '{2, 29,  0, 59, 0, 2, 1, 1, 0};
        vt[22] = '{2, 1,   0, 0, 0, 2, 1, 1, 0};
        vt[23] = '{0, 1,   0, 0, 0, 3, 1, 1, 0};
        vt[24] = '{2, 59,  0, 0, 59, 3, 1, 1, 0};
        vt[25] = '{2, 1,   0, 0, 0, 3, 1, 1, 0};
        vt[26] = '{2, 1,   0, 0, 1, 3, 1, 1, 0};
        vt[27] = '{1, 1,   0, 0, 1, 0, 1, 1, 0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("reset_outputs", int'({bus.hour, bus.min, bus.sec, bus.time_c, bus.alm_c,
                                   bus.editing, bus.field}), 0);

        for (int i = 0; i < 28; i++) begin
            tap(vt[i].btn, vt[i].n);
            chk($sformatf("v%0d_hour", i), int'(bus.hour), vt[i].hour);
            chk($sformatf("v%0d_min", i), int'(bus.min), vt[i].min);
            chk($sformatf("v%0d_sec", i), int'(bus.sec), vt[i].sec);
            chk($sformatf("v%0d_field", i), int'(bus.field), vt[i].field);
            chk($sformatf("v%0d_editing", i), int'(bus.editing), (vt[i].field != 0) ? 1 : 0);
            chk($sformatf("v%0d_time_c_cnt", i), tc_cnt, vt[i].tc);
            chk($sformatf("v%0d_alm_c_cnt", i), ac_cnt, vt[i].ac);
            if (vt[i].snap) begin
                chk($sformatf("v%0d_strobe_hour", i), snap_h, vt[i].hour);
                chk($sformatf("v%0d_strobe_min", i), snap_m, vt[i].min);
                chk($sformatf("v%0d_strobe_sec", i), snap_s, vt[i].sec);
            end
        end

        // Glitch rejection and press latency in HOUR (hour starts at 0).
        tap(0, 1);
        chk("glitch_pre_field", int'(bus.field), 1);
        bus.btn_inc = 1'b1;
        repeat (3) @(negedge clk);
        bus.btn_inc = 1'b0;
        repeat (15) @(negedge clk);
        chk("glitch_hour", int'(bus.hour), 0);

        h0 = bus.hour;
        lat = -1;
        bus.btn_inc = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (lat < 0 && bus.hour != h0) lat = k;
        end
        bus.btn_inc = 1'b0;
        chk("press_latency", lat, 7);
        repeat (15) @(negedge clk);
        chk("hold10_single_inc", int'(bus.hour), 1);

        // Reset during MIN with btn_inc held.
        tap(0, 1);
        chk("rst_pre_field", int'(bus.field), 2);
        bus.btn_inc = 1'b1;
        repeat (12) @(negedge clk);
        chk("rst_pre_min", int'(bus.min), 1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_mid_outputs", int'({bus.hour, bus.min, bus.sec, bus.time_c, bus.alm_c,
                                     bus.editing, bus.field}), 0);
        tap(0, 1);
        chk("rst_held_field", int'(bus.field), 1);
        repeat (30) @(negedge clk);
        chk("rst_held_no_inc", int'(bus.hour), 0);
        bus.btn_inc = 1'b0;
        repeat (20) @(negedge clk);
        tap(2, 1);
        chk("rst_repress_inc", int'(bus.hour), 1);

        // Long hold in MIN from 0.
        tap(0, 1);
        chk("rep_pre_field", int'(bus.field), 2);
        chk("rep_pre_min", int'(bus.min), 0);
        bus.btn_inc = 1'b1;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (lat < 0 && bus.min != 6'd0) lat = k;
            if (lat > 0) break;
        end
        chk("rep_first_press_seen", (lat > 0) ? 1 : 0, 1);
        repeat (30) @(negedge clk);
        bus.btn_inc = 1'b0;
        repeat (60) @(negedge clk);
`ifdef TIME_SET_AUTOREPEAT_EN
        exp_rep = 5;
`else
        exp_rep = 1;
`endif
        chk("rep_min", int'(bus.min), exp_rep);
        chk("final_time_c_cnt", tc_cnt, 1);
        chk("final_alm_c_cnt", ac_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 The module SHALL have parameter DEB_CYCLES, default 500000, the number of consecutive stable synchronized samples required to accept a button level change.
REQ-002 The module SHALL have parameter REP_DELAY, default 25000000, the hold time in cycles before the first auto-repeat increment.
REQ-003 The module SHALL have parameter REP_PERIOD, default 10000000, the interval in cycles between subsequent auto-repeat increments.
REQ-004 clk  in  1  single system clock; all logic on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 btn_mode  in  1  raw asynchronous button; enters time edit from idle, advances field in edit.
REQ-007 btn_alm  in  1  raw asynchronous button; enters alarm edit from idle, aborts when in edit.
REQ-008 btn_inc  in  1  raw asynchronous button; increments the active field.
REQ-009 sec, min, hour  out  6 each  edit-register values presented to the clock core.
REQ-010 time_c  out  1  one-cycle load strobe for the current time.
REQ-011 alm_c  out  1  one-cycle load strobe for the alarm time.
REQ-012 editing  out  1  high in any edit state.
REQ-013 field  out  2  active field: 0 none, 1 hour, 2 min, 3 sec.

Function
REQ-014 Each button SHALL pass through a 2-flop synchronizer and then a debounce counter; the debounced level changes only after DEB_CYCLES consecutive equal synchronized samples.
REQ-015 Each button SHALL produce a one-cycle press pulse on the debounced 0->1 edge; latency from raw rise to the resulting register change SHALL be exactly DEB_CYCLES+3 cycles.
REQ-016 The FSM SHALL have states IDLE, HOUR, MIN, SEC, COMMIT.
REQ-017 IDLE: mode press -> HOUR with target=time; alm press -> HOUR with target=alarm; on simultaneous presses, mode wins.
REQ-018 On entry to HOUR from IDLE, the edit registers SHALL keep their current values (no clear).
REQ-019 HOUR: inc press -> hour=(hour+1) mod 24; mode press -> MIN.
REQ-020 MIN: inc press -> min=(min+1) mod 60; mode press -> SEC.
REQ-021 SEC: inc press -> sec=(sec+1) mod 60; mode press -> COMMIT.
REQ-022 When inc and mode press in the same cycle, the increment SHALL apply to the current field and the FSM SHALL then advance.
REQ-023 An alm press in HOUR/MIN/SEC SHALL abort to IDLE with no strobe; abort takes priority over mode and inc in the same cycle; edited values remain on the outputs.
REQ-024 COMMIT SHALL last exactly one cycle and assert time_c or alm_c (per latched target) for that cycle only, then return to IDLE.
REQ-025 time_c and alm_c SHALL never be high simultaneously and SHALL never be high outside COMMIT.
REQ-026 sec/min/hour SHALL be stable during the strobe cycle and never exceed 59/59/23.
REQ-027 editing=1 and field=1/2/3 in HOUR/MIN/SEC; editing=0 and field=0 in IDLE and COMMIT.
REQ-028 inc presses in IDLE and COMMIT SHALL be ignored.

Reset
REQ-029 rst SHALL force state IDLE, sec=min=hour=0, time_c=alm_c=0, editing=0, field=0, target=time, synchronizers, debounced levels and all counters to 0.
REQ-030 rst asserted mid-edit or during COMMIT SHALL suppress any pending strobe; a button held through reset release SHALL not produce a press until released and re-pressed.

Configuration
REQ-031 With TIME_SET_AUTOREPEAT_EN defined, holding debounced btn_inc in HOUR/MIN/SEC SHALL generate an extra increment REP_DELAY cycles after the press, then every REP_PERIOD cycles until release or field change; the repeat counter restarts on each field change.
REQ-032 Without TIME_SET_AUTOREPEAT_EN, each press SHALL give exactly one increment; REP_DELAY/REP_PERIOD SHALL have no effect and no repeat logic SHALL be synthesized.

Verification (DEB_CYCLES=4, REP_DELAY=20, REP_PERIOD=5)
REQ-033 Reset, then mode, inc x3, mode, inc x2, mode, mode -> one-cycle time_c with hour=3, min=2, sec=0; alm_c stays 0.
REQ-034 From hour=23 in HOUR, inc press -> hour=0; from min=59 in MIN, inc -> min=0.
REQ-035 btn_inc glitch high for 3 cycles -> no change; held high 10 cycles -> exactly one increment, 7 cycles after rise.
REQ-036 alm press in IDLE, edits to 06:30:00, mode to COMMIT -> alm_c pulse only; alm press mid-edit in a second pass -> IDLE, no strobe.
REQ-037 rst asserted during MIN with btn_inc held -> all outputs 0, IDLE; no increment after reset release until btn_inc is re-pressed.
REQ-038 With macro: hold inc 40 cycles after debounce in MIN from 0 -> min=5 (1 press + 4 repeats); without macro -> min=1.
